// File: rtl/ecg_layer_argmax.sv
// Output stage of the ECG classifier: waits for node latency, captures all class
// scores, scans them for the maximum and hands index/score/tie over valid/ready.
module ecg_layer_argmax #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned LAT_WAIT    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [8*NUM_CLASSES-1:0] n_flat,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         class_idx,
  output logic [7:0]               max_val,
  output logic                     tie
);

  localparam int unsigned CNT_W = $clog2(LAT_WAIT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LAT_WAIT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       bank_q [NUM_CLASSES];
  logic [7:0]       bank_d [NUM_CLASSES];
  logic [7:0]       best_q, best_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             tie_r_q, tie_r_d;
  logic [IDX_W-1:0] class_idx_q, class_idx_d;
  logic [7:0]       max_val_q, max_val_d;
  logic             tie_q, tie_d;
  logic [7:0]       cand;

  assign cand = bank_q[idx_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    bank_d      = bank_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    tie_r_d     = tie_r_q;
    class_idx_d = class_idx_q;
    max_val_d   = max_val_q;
    tie_d       = tie_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            bank_d[i] = n_flat[8*i +: 8];
          end
          best_d     = n_flat[7:0];
          best_idx_d = '0;
          tie_r_d    = 1'b0;
          idx_d      = IDX_W'(1);
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SCAN: begin
        // Strict greater-than keeps the lowest index on equal scores.
        if (cand > best_q) begin
          best_d     = cand;
          best_idx_d = idx_q;
          tie_r_d    = 1'b0;
        end else if (cand == best_q) begin
          tie_r_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          class_idx_d = best_idx_d;
          max_val_d   = best_d;
          tie_d       = tie_r_d;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      bank_q      <= '{default: '0};
      best_q      <= '0;
      best_idx_q  <= '0;
      tie_r_q     <= 1'b0;
      class_idx_q <= '0;
      max_val_q   <= '0;
      tie_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      bank_q      <= bank_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      tie_r_q     <= tie_r_d;
      class_idx_q <= class_idx_d;
      max_val_q   <= max_val_d;
      tie_q       <= tie_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign class_idx = class_idx_q;
  assign max_val   = max_val_q;
  assign tie       = tie_q;

endmodule

// File: tb/tb_ecg_layer_argmax.sv
// Directed bench for ecg_layer_argmax: vector table plus timing, backpressure,
// spurious-start and mid-scan reset sequences.
module tb_ecg_layer_argmax;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [79:0] n_flat;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  class_idx;
  logic [7:0]  max_val;
  logic        tie;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ecg_layer_argmax #(.NUM_CLASSES(10), .IDX_W(4), .LAT_WAIT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n_flat    (n_flat),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_idx (class_idx),
    .max_val   (max_val),
    .tie       (tie)
  );

  typedef struct {
    logic [79:0] flat;
    logic [3:0]  exp_idx;
    logic [7:0]  exp_max;
    logic        exp_tie;
  } vec_t;

  function automatic logic [79:0] pk(input int s0, s1, s2, s3, s4, s5, s6, s7, s8, s9);
    return {s9[7:0], s8[7:0], s7[7:0], s6[7:0], s5[7:0],
            s4[7:0], s3[7:0], s2[7:0], s1[7:0], s0[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result(input string name, input vec_t v);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_idx"},   32'(class_idx), 32'(v.exp_idx));
    chk({name, "_max"},   32'(max_val),   32'(v.exp_max));
    chk({name, "_tie"},   32'(tie),       32'(v.exp_tie));
  endtask

  // Full operation with out_ready=1: valid must appear exactly after edge E0+11.
  task automatic run_vec(input string name, input vec_t v);
    logic early;
    n_flat    = v.flat;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();                      // E0
    start = 1'b0;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    early = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (out_valid) early = 1'b1;
    end
    chk({name, "_early_valid"}, 32'(early), 32'd0);
    tick();                      // E11
    chk_result(name, v);
    tick();
    chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({name, "_busy_drop"},  32'(busy),      32'd0);
  endtask

  vec_t tbl[7];
  vec_t v;
  logic stable;
  logic seen;
  logic [79:0] a_flat, b_flat;

  initial begin
    tbl[0] = '{pk(5,9,0,40,3,127,2,126,1,7),  4'd5, 8'd127, 1'b0};
    tbl[1] = '{pk(0,0,0,30,0,0,0,0,30,0),     4'd3, 8'd30,  1'b1};
    tbl[2] = '{pk(0,0,0,0,0,0,0,0,0,0),       4'd0, 8'd0,   1'b1};
    tbl[3] = '{pk(1,2,3,4,5,6,7,8,9,10),      4'd9, 8'd10,  1'b0};
    tbl[4] = '{pk(50,50,0,0,0,0,0,0,0,60),    4'd9, 8'd60,  1'b0};
    tbl[5] = '{pk(127,0,0,0,0,0,0,0,0,127),   4'd0, 8'd127, 1'b1};
    tbl[6] = '{pk(100,0,0,0,0,0,0,0,0,99),    4'd0, 8'd100, 1'b0};

    reset = 1'b1; start = 1'b0; out_ready = 1'b0; n_flat = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx",   32'(class_idx), 32'd0);
    chk("rst_max",   32'(max_val),   32'd0);
    chk("rst_tie",   32'(tie),       32'd0);
    tick();

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
      tick();
    end

    // Capture edge: only E0+2 sees B (index2=100); A (index9=120) elsewhere.
    a_flat = pk(0,0,0,0,0,0,0,0,0,120);
    b_flat = pk(0,0,100,0,0,0,0,0,0,0);
    n_flat = a_flat; out_ready = 1'b1; start = 1'b1;
    tick();                      // E0
    start = 1'b0;
    tick();                      // E1
    n_flat = b_flat;
    tick();                      // E2 captures B
    n_flat = a_flat;
    for (int k = 3; k <= 11; k++) tick();
    v = '{b_flat, 4'd2, 8'd100, 1'b0};
    chk_result("capture", v);
    tick(); tick();

    // Backpressure: outputs frozen while out_ready=0.
    n_flat = tbl[0].flat; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 11; k++) tick();
    chk_result("bp_first", tbl[0]);
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!out_valid || class_idx !== 4'd5 || max_val !== 8'd127 || tie !== 1'b0 || !busy)
        stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_busy_drop",  32'(busy),      32'd0);
    chk("bp_idx_kept",   32'(class_idx), 32'd5);
    chk("bp_max_kept",   32'(max_val),   32'd127);
    tick();

    // Spurious starts during WAIT, SCAN, DONE and on the accepting edge.
    n_flat = tbl[1].flat; out_ready = 1'b0; start = 1'b1;
    tick();                      // E0
    start = 1'b1; tick(); start = 1'b0;   // E1 in WAIT
    for (int k = 2; k <= 5; k++) tick();
    start = 1'b1; tick(); start = 1'b0;   // E6 in SCAN
    for (int k = 7; k <= 11; k++) tick();
    chk_result("xs", tbl[1]);
    start = 1'b1; tick(); tick(); start = 1'b0; // DONE, no accept
    chk("xs_hold_valid", 32'(out_valid), 32'd1);
    start = 1'b1; out_ready = 1'b1;
    tick();                      // accepting edge with start high
    start = 1'b0;
    chk("xs_busy_after_accept", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out_valid || busy) seen = 1'b1;
    end
    chk("xs_no_second_result", 32'(seen), 32'd0);
    run_vec("xs_after", tbl[3]);
    tick();

    // Reset mid-scan at E0+6, then a fresh run.
    n_flat = tbl[0].flat; out_ready = 1'b1; start = 1'b1;
    tick();                      // E0
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    reset = 1'b1;
    tick();                      // E6 with reset
    reset = 1'b0;
    chk("mr_busy",  32'(busy),      32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_idx",   32'(class_idx), 32'd0);
    chk("mr_max",   32'(max_val),   32'd0);
    chk("mr_tie",   32'(tie),       32'd0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("mr_abandoned", 32'(seen), 32'd0);
    run_vec("mr_fresh", tbl[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecg_layer_argmax.md
Name: ecg_layer_argmax

Overview:
- Output stage of the ECG classifier network; sits directly downstream of the final-layer neuron nodes.
- Waits a fixed pipeline latency after the upstream launch, then snapshots all class scores (8-bit ReLU-saturated, 0..127) and scans them sequentially to find the winning class.
- Presents class index, winning score and a tie flag through a valid/ready handshake to the host/readout logic.

Parameters:
- NUM_CLASSES, 10, number of class scores on n_flat (>=2).
- IDX_W, 4, width of class_idx (2^IDX_W >= NUM_CLASSES).
- LAT_WAIT, 2, clock edges between the start sample and the score capture. Matches node latency: input register, then accumulator, then output register. Must be >=1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse, same cycle node inputs are applied; honoured only in IDLE.
- n_flat  input  8*NUM_CLASSES  class scores; score i = n_flat[8*i+7:8*i], unsigned.
- busy  output  1  high in WAIT, SCAN and DONE.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- class_idx  output  IDX_W  index of maximum score.
- max_val  output  8  maximum score.
- tie  output  1  another index holds a score equal to max_val.

Behaviour:
- Reset, synchronous, has priority over everything, any state:
  - state=IDLE; busy=0, out_valid=0, class_idx=0, max_val=0, tie=0.
  - wait counter, scan index and score bank are cleared.
  - An operation in progress is abandoned with no output.
- States: IDLE, WAIT, SCAN, DONE.
- IDLE:
  - start=1 at edge E0 -> WAIT, counter=1.
  - start=0 -> stay.
- WAIT:
  - Counter increments each edge.
  - At edge E0+LAT_WAIT: capture all NUM_CLASSES scores into the bank; best=score0, best_idx=0, tie_r=0, scan index=1; -> SCAN.
  - n_flat is don't-care outside the capture edge.
- SCAN, one compare per edge using bank entry i:
  - bank[i] > best: best=bank[i], best_idx=i, tie_r=0.
  - bank[i] == best: tie_r=1.
  - else: no change.
  - Comparison is unsigned 8-bit. Strict greater-than, so the lowest index wins ties.
  - After comparing i=NUM_CLASSES-1 -> DONE. Outputs load from best/best_idx/tie_r on that same edge; out_valid=1.
  - Last compare at edge E0+LAT_WAIT+NUM_CLASSES-1 (edge 11 for defaults).
- DONE:
  - out_valid, class_idx, max_val, tie are held stable until out_ready=1 is sampled.
  - That edge -> IDLE; out_valid=0 after it. class_idx/max_val/tie keep their last values.
- start is ignored outside IDLE, including the edge that leaves DONE. Nothing is queued.
- out_ready is ignored outside DONE.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Scores {5,9,0,40,3,127,2,126,1,7}, start pulse, out_ready=1 -> out_valid rises after edge 11 (LAT_WAIT=2), class_idx=5, max_val=127, tie=0, single-cycle valid.
- Scores {0,0,0,30,0,0,0,0,30,0} -> class_idx=3, max_val=30, tie=1. All-zero scores -> class_idx=0, max_val=0, tie=1.
- Score capture timing:
  - n_flat holds {...index 2=100...} only at capture edge E0+2.
  - Different values at E0+1 and E0+3 (index 9=120).
  - Expected: class_idx=2, max_val=100.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and outputs stable. Raise out_ready -> one edge later out_valid=0, busy=0.
- Extra start pulses during WAIT/SCAN/DONE, including the accepting edge -> ignored, no second result. A start in IDLE afterward runs normally.
- Assert reset at a SCAN cycle (E0+6) -> next edge busy=0, out_valid=0, all outputs 0. A subsequent start produces a correct fresh result.
